// File: rtl/rcs_pkg.sv
// Shared definitions for the bit-serial ripple-borrow subtractor: FSM encoding and default width.
// No logic and no latency of its own.
package rcs_pkg;

  localparam int RCS_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_ripple_subtractor_if.sv
// Request/result bundle between a controller (master) and the serial subtractor (slave).
// Optional ovf result bit exists only when RCS_SIGNED_OVF_EN is defined.
interface seq_ripple_subtractor_if
  import rcs_pkg::*;
#(
  parameter int N = RCS_N_DEFAULT
);

  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [N-1:0] diff_out;
  logic         borrow_out;
`ifdef RCS_SIGNED_OVF_EN
  logic         ovf;
`endif

  modport master (
    output start, a, b, borrow_in,
`ifdef RCS_SIGNED_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff_out, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
`ifdef RCS_SIGNED_OVF_EN
    output ovf,
`endif
    output busy, done, diff_out, borrow_out
  );

endinterface

// File: rtl/full_subtractor.sv
// 1-bit full subtractor: d = x - y - bin, bout set when the bit position underflows.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_xy;

  assign w_xy = x ^ y;
  assign d    = w_xy ^ bin;
  assign bout = (~x & y) | (~w_xy & bin);

endmodule

// File: rtl/seq_ripple_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first; done pulses N+1 cycles after start is sampled, start ignored while busy.
// RCS_SIGNED_OVF_EN adds a registered two's-complement overflow flag alongside diff_out.
module seq_ripple_subtractor
  import rcs_pkg::*;
#(
  parameter int N = RCS_N_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seq_ripple_subtractor_if.slave  s
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic [N-1:0]  r_sh;
  logic [N-1:0]  r_diff;
  logic [CW-1:0] r_cnt;
  logic          r_br;
  logic          r_bout;
  logic          w_d;
  logic          w_bout;
  logic          w_accept;
  logic          w_last;
`ifdef RCS_SIGNED_OVF_EN
  logic          r_ovf;
`endif

  // Operands shift right each bit, so the cell always sees the current bit at index 0.
  full_subtractor u_fs (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (s.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_sh   <= '0;
      r_diff <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
`ifdef RCS_SIGNED_OVF_EN
      r_ovf  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a   <= s.a;
      r_b   <= s.b;
      r_br  <= s.borrow_in;
      r_sh  <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a  <= r_a >> 1;
      r_b  <= r_b >> 1;
      r_br <= w_bout;
      r_sh <= {w_d, r_sh[N-1:1]};
      if (w_last) begin
        r_diff <= {w_d, r_sh[N-1:1]};
        r_bout <= w_bout;
`ifdef RCS_SIGNED_OVF_EN
        // On the last bit r_a[0]/r_b[0] are the operand sign bits.
        r_ovf  <= (r_a[0] ^ r_b[0]) & (r_a[0] ^ w_d);
`endif
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign s.busy       = (r_state != IDLE);
  assign s.done       = (r_state == DONE);
  assign s.diff_out   = r_diff;
  assign s.borrow_out = r_bout;
`ifdef RCS_SIGNED_OVF_EN
  assign s.ovf        = r_ovf;
`endif

endmodule

// File: tb/tb_seq_ripple_subtractor.sv
// Directed bench for seq_ripple_subtractor: arithmetic reference model with per-cycle compare
// plus literal checks of each directed result, start-while-busy and mid-operation reset.
module tb_seq_ripple_subtractor;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic chk_en;
  int   tests = 0;
  int   fails = 0;

  seq_ripple_subtractor_if #(.N(N)) bus ();

  seq_ripple_subtractor #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic logic [N-1:0] f_diff(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin);
    return r[N-1:0];
  endfunction

  function automatic logic f_borrow(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    return int'(a) < (int'(b) + int'(bin));
  endfunction

  function automatic logic f_ovf(input logic [N-1:0] a, input logic [N-1:0] b, input logic bin);
    int sa, sb, r;
    sa = a[N-1] ? int'(a) - (1 << N) : int'(a);
    sb = b[N-1] ? int'(b) - (1 << N) : int'(b);
    r  = sa - sb - int'(bin);
    return (r < -(1 << (N - 1))) || (r > (1 << (N - 1)) - 1);
  endfunction

  // Model: phase 0 idle, 1..N computing, N+1 done pulse.
  int           m_phase;
  logic [N-1:0] m_diff, p_diff;
  logic         m_bout, m_ovf, p_bout, p_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_diff  <= '0;
      m_bout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_phase == 0) begin
      if (bus.start === 1'b1) begin
        m_phase <= 1;
        p_diff  <= f_diff(bus.a, bus.b, bus.borrow_in);
        p_bout  <= f_borrow(bus.a, bus.b, bus.borrow_in);
        p_ovf   <= f_ovf(bus.a, bus.b, bus.borrow_in);
      end
    end else if (m_phase == N + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase == N) begin
        m_diff <= p_diff;
        m_bout <= p_bout;
        m_ovf  <= p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("model_busy", 32'(bus.busy), 32'(m_phase != 0));
      chk("model_done", 32'(bus.done), 32'(m_phase == N + 1));
      chk("model_diff", 32'(bus.diff_out), 32'(m_diff));
      chk("model_borrow", 32'(bus.borrow_out), 32'(m_bout));
`ifdef RCS_SIGNED_OVF_EN
      chk("model_ovf", 32'(bus.ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_diff"}, 32'(bus.diff_out), 0);
    chk({tag, "_borrow"}, 32'(bus.borrow_out), 0);
`ifdef RCS_SIGNED_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 0);
`endif
  endtask

  task automatic check_result(input string tag, input int ed, input int eb, input int eo);
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    chk({tag, "_diff"}, 32'(bus.diff_out), 32'(ed));
    chk({tag, "_borrow"}, 32'(bus.borrow_out), 32'(eb));
`ifdef RCS_SIGNED_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
`else
    if (eo < 0) $display("note: negative ovf literal in %s", tag);
`endif
  endtask

  // Present a request, scramble inputs after acceptance, check done timing and result.
  task automatic run_op(input string tag, input int a, input int b, input int bin,
                        input int ed, input int eb, input int eo);
    @(negedge clk);
    bus.a         = N'(a);
    bus.b         = N'(b);
    bus.borrow_in = 1'(bin);
    bus.start     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.a         = ~N'(a);
    bus.b         = ~N'(b);
    bus.borrow_in = ~1'(bin);
    repeat (N - 1) @(negedge clk);
    chk({tag, "_pre_done"}, 32'(bus.done), 0);
    @(negedge clk);
    check_result(tag, ed, eb, eo);
    @(negedge clk);
    chk({tag, "_post_done"}, 32'(bus.done), 0);
    chk({tag, "_post_busy"}, 32'(bus.busy), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;
    chk_en        = 1'b0;
    rst_n         = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_idle_zero("reset");
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("t5m3",    5,   3, 0,   2, 0, 0);
    run_op("t3m5",    3,   5, 0, 254, 1, 0);
    run_op("t32m32b", 32, 32, 1, 255, 1, 0);
    run_op("t32m0b",  32,  0, 1,  31, 0, 0);
    run_op("t128m1", 128,  1, 0, 127, 0, 1);

    // Second start during RUN must be ignored.
    @(negedge clk);
    bus.a = N'(22); bus.b = N'(11); bus.borrow_in = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.a = '0; bus.b = N'(1); bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_mid_run", 32'(bus.busy), 1);
    repeat (N - 3) @(negedge clk);
    check_result("collide", 11, 0, 0);
    repeat (3) @(negedge clk);
    chk("collide_not_queued", 32'(bus.busy), 0);
    chk("collide_hold_diff", 32'(bus.diff_out), 11);

    // Reset mid-operation abandons the request.
    @(negedge clk);
    bus.a = N'(200); bus.b = N'(100); bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_idle_zero("midrun_reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    run_op("after_reset", 1, 1, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_ripple_subtractor.md
Name: seq_ripple_subtractor

Overview:
- Bit-serial ripple-borrow subtractor, the inverse operation of the team's combinational generate-based ripple-carry adder.
- Computes diff = a - b - borrow_in, one bit per clock, LSB first, through a single 1-bit full-subtractor cell.
- Uses a start/busy/done handshake so a controller can trade area for latency against the parallel adder.

Parameters:
- N, 8, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  N  minuend; latched when start is accepted.
- b  input  N  subtrahend; latched when start is accepted.
- borrow_in  input  1  initial borrow; latched when start is accepted.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, high in DONE only.
- diff_out  output  N  result; valid from done, held until the next accepted start.
- borrow_out  output  1  final borrow; same validity as diff_out.

Behaviour:
- Reset: rst_n low asynchronously forces the following, at any time including mid-operation (the operation is abandoned):
  - state = IDLE
  - busy = 0, done = 0
  - diff_out = 0, borrow_out = 0
  - internal operand/shift registers = 0, bit counter = 0, borrow register = 0
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on a rising edge with start = 1:
  - latch a, b and borrow_in
  - clear the bit counter
  - diff_out and borrow_out keep their previous values until DONE
- RUN, one bit per edge, index i = counter, br = borrow register:
  - d = a[i] ^ b[i] ^ br
  - br_next = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br)
  - d shifts into the result shift register from the MSB side, so after N shifts bit i sits at position i
  - counter increments
- RUN -> DONE on the edge that processes i = N-1. On that same edge:
  - diff_out <= completed result
  - borrow_out <= br_next
- DONE -> IDLE unconditionally after one cycle.
- Latency: start sampled at edge k; done high during the cycle after edge k+N; the next start can be accepted at edge k+N+2.
- start while busy (RUN or DONE) is ignored; it is not queued.
- a, b and borrow_in may change freely after acceptance; only latched copies are used.
- Arithmetic is modulo 2^N. borrow_out = 1 iff a < b + borrow_in (unsigned).
- Counter width: clog2(N) bits. No wrap-around issue, since the counter is cleared on start and stops at N-1.

Optional Feature:
- Macro: RCS_SIGNED_OVF_EN.
- Defined:
  - adds output port ovf (1 bit).
  - On the RUN->DONE edge: ovf <= (a[N-1] ^ b[N-1]) & (a[N-1] ^ d[N-1]), i.e. two's-complement overflow of a - b - borrow_in.
  - ovf has the same reset value (0) and hold rules as diff_out.
- Undefined: port ovf and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header rcs_pkg holds:
  - the state encoding constants IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2
  - the default width constant RCS_N_DEFAULT = 8
- One natural sub-module: full_subtractor, 1-bit combinational, with inputs x, y, bin and outputs d, bout. It is instantiated once, with the FSM/datapath in the top level.

Test Plan (N = 8, done checked exactly 9 cycles after the start edge):
- a=5, b=3, borrow_in=0 -> diff_out=2, borrow_out=0; done pulses exactly one cycle.
- a=3, b=5, borrow_in=0 -> diff_out=254, borrow_out=1; with RCS_SIGNED_OVF_EN, ovf=0.
- a=32, b=32, borrow_in=1 -> diff_out=255, borrow_out=1. Then a=32, b=0, borrow_in=1 -> diff_out=31, borrow_out=0.
- a=128, b=1, borrow_in=0 -> diff_out=127, borrow_out=0; with RCS_SIGNED_OVF_EN, ovf=1.
- Start a=22, b=11; pulse start again with a=0, b=1 at cycle 3 of RUN -> second request ignored; result is 11; busy is never dropped early.
- Start a=200, b=100; assert rst_n low at cycle 4 of RUN -> outputs immediately 0, state IDLE. After release, a fresh start with a=1, b=1 -> diff_out=0, borrow_out=0 at normal latency.
